// File: rtl/fifo_unpacker_pkg.sv
// Shared types and sizing helpers for the sync_fifo drain/unpack stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_unpacker_pkg;

    // Read-issue FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_BACKOFF = 2'd2
    } state_e;

    localparam int IN_W_DFLT      = 64;
    localparam int OUT_W_DFLT     = 16;
    localparam int BUF_DEPTH_DFLT = 2;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Narrow beats per FIFO word.
    function automatic int ratio_of(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Lane index width for a given beat ratio.
    function automatic int lane_w_of(input int ratio);
        return width_of(ratio);
    endfunction

    // Width of a counter that must reach 'depth' inclusive (occupancy).
    function automatic int cnt_w_of(input int depth);
        return width_of(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_unpacker_buf.sv
// Small register FIFO holding full words awaiting unpack.
// Latency: push visible at head one cycle later; pop takes effect next cycle.
// Backpressure: none; caller guarantees space before push and data before pop.
module fifo_unpacker_buf
    import fifo_unpacker_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH_DFLT,
    parameter int W     = IN_W_DFLT,
    parameter int CNT_W = cnt_w_of(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_head,
    output logic [CNT_W-1:0] o_occ
);

    localparam int PTR_W = width_of(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;

    // Pointer and occupancy next state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (i_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({i_push, i_pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Word storage; contents are only observed while occupancy is non-zero.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    assign o_head = mem_q[rd_ptr_q];
    assign o_occ  = occ_q;

endmodule

// File: rtl/fifo_unpacker.sv
// Drains sync_fifo with credit-limited speculative reads and splits words into LSB-first beats.
// Latency: RD_LAT cycles read-to-capture, one more cycle to first beat; 1 beat/cycle sustained.
// Backpressure: i_ready low holds o_data and lane; read issue stops when buffer credit runs out.
module fifo_unpacker
    import fifo_unpacker_pkg::*;
#(
    parameter int IN_W      = IN_W_DFLT,
    parameter int OUT_W     = OUT_W_DFLT,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = BUF_DEPTH_DFLT,
    parameter int BACKOFF   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic             o_fifo_rden,
    input  logic [IN_W-1:0]  i_fifo_data,
    input  logic             i_fifo_data_vld,
    input  logic             i_fifo_underflow,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_proto_err
);

    localparam int RATIO  = ratio_of(IN_W, OUT_W);
    localparam int LANE_W = lane_w_of(RATIO);
    localparam int CNT_W  = cnt_w_of(BUF_DEPTH);
    localparam int IF_W   = cnt_w_of(RD_LAT);
    localparam int BO_W   = width_of(BACKOFF);

    state_e            state_q, state_d;
    logic [BO_W-1:0]   cnt_q, cnt_d;
    logic [RD_LAT-1:0] sr_q, sr_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              err_q, err_d;

    logic              rden;
    logic              tail;
    logic              uf_rsp;
    logic              push;
    logic              pop;
    logic              fire;
    logic              last_lane;
    logic              credit;
    logic [31:0]       used;
    logic [IF_W-1:0]   inflight;
    logic [CNT_W-1:0]  occ;
    logic [IN_W-1:0]   head;
    logic [OUT_W-1:0]  beat;

    assign tail   = sr_q[RD_LAT-1];
    assign uf_rsp = tail & i_fifo_underflow;
    assign push   = tail & i_fifo_data_vld;

    // Count reads issued but not yet resolved.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IF_W'(sr_q[i]);
        end
    end

    // Credit uses registered occupancy only, so a same-cycle pop never grants an extra read.
    always_comb begin
        used   = 32'(occ) + 32'(inflight);
        credit = (used < 32'(BUF_DEPTH));
    end

    // Issue FSM next state and read strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rden    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (uf_rsp && (BACKOFF > 0)) begin
                    state_d = ST_BACKOFF;
                    cnt_d   = BO_W'(BACKOFF - 1);
                end else if (!i_en) begin
                    state_d = ST_IDLE;
                end else begin
                    rden = credit;
                end
            end
            ST_BACKOFF: begin
                if (cnt_q == '0) begin
                    state_d = i_en ? ST_FETCH : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - BO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // In-flight tracking shift register and sticky protocol error.
    always_comb begin
        sr_d  = (sr_q << 1) | RD_LAT'(rden);
        err_d = err_q
              | (tail & (i_fifo_data_vld == i_fifo_underflow))
              | (!tail & (i_fifo_data_vld | i_fifo_underflow));
    end

    // Lane stepping; the head word pops when its last lane is accepted.
    always_comb begin
        fire      = o_valid & i_ready;
        last_lane = (lane_q == LANE_W'(RATIO - 1));
        pop       = fire & last_lane;
        lane_d    = lane_q;
        if (fire) begin
            lane_d = last_lane ? '0 : lane_q + LANE_W'(1);
        end
    end

    // Select the current lane of the head word.
    always_comb begin
        beat = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_q == LANE_W'(i)) begin
                beat = head[i*OUT_W +: OUT_W];
            end
        end
    end

    // All control state; reset forgets any reads still in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            lane_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
        end
    end

    fifo_unpacker_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (IN_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (i_fifo_data),
        .i_pop       (pop),
        .o_head      (head),
        .o_occ       (occ)
    );

    assign o_fifo_rden = rden;
    assign o_valid     = (occ != '0);
    assign o_data      = o_valid ? beat : '0;
    assign o_busy      = o_valid | (sr_q != '0);
    assign o_proto_err = err_q;

endmodule

// File: tb/tb_fifo_unpacker.sv
module tb_fifo_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rden;
    logic [63:0] fdat;
    logic        fvld;
    logic        fuf;
    logic [15:0] odata;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        perr;

    // sync_fifo stand-in with one cycle read latency.
    logic [63:0] words [128];
    int          n_words = 0;
    int          rd_idx  = 0;
    logic        mdl_vld;
    logic        mdl_uf;
    logic [63:0] mdl_dat;
    logic        inj_vld;

    // Expected beat scoreboard: main process writes, monitor consumes.
    logic [15:0] exp_beats [1024];
    int          exp_wr = 0;
    int          exp_rd = 0;

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          gap_chk = 1'b0;

    assign fvld = mdl_vld | inj_vld;
    assign fuf  = mdl_uf;
    assign fdat = mdl_dat;

    always #5 clk = ~clk;

    fifo_unpacker #(
        .IN_W      (64),
        .OUT_W     (16),
        .RD_LAT    (1),
        .BUF_DEPTH (2),
        .BACKOFF   (4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_en             (en),
        .o_fifo_rden      (rden),
        .i_fifo_data      (fdat),
        .i_fifo_data_vld  (fvld),
        .i_fifo_underflow (fuf),
        .o_data           (odata),
        .o_valid          (valid),
        .i_ready          (ready),
        .o_busy           (busy),
        .o_proto_err      (perr)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx  <= n_words;
            mdl_vld <= 1'b0;
            mdl_uf  <= 1'b0;
            mdl_dat <= '0;
        end else begin
            mdl_vld <= 1'b0;
            mdl_uf  <= 1'b0;
            if (rden) begin
                if (rd_idx < n_words) begin
                    mdl_vld <= 1'b1;
                    mdl_dat <= words[rd_idx];
                    rd_idx  <= rd_idx + 1;
                end else begin
                    mdl_uf <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_put(input logic [63:0] w);
        words[n_words] = w;
        n_words++;
    endtask

    task automatic exp_put(input logic [15:0] b);
        exp_beats[exp_wr] = b;
        exp_wr++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input int bound);
        int c = 0;
        while (exp_rd != exp_wr && c < bound) begin
            tick();
            c++;
        end
        check("drain_done", 64'(exp_wr - exp_rd), 64'd0);
    endtask

    // Monitor: compares every accepted beat and the hold/gap/occupancy properties.
    initial begin
        logic [15:0] prev_data;
        bit          prev_stall;
        bit          prev_fire;
        prev_data  = '0;
        prev_stall = 1'b0;
        prev_fire  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_rd     = exp_wr;
                prev_stall = 1'b0;
                prev_fire  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", 64'(odata), 64'(prev_data));
                end
                if (gap_chk && prev_fire && exp_rd != exp_wr) begin
                    check("no_gap_valid", 64'(valid), 64'd1);
                end
                n_chk++;
                if (dut.u_buf.o_occ > 2) begin
                    n_fail++;
                    $display("FAIL occ_max: occ=%0d, limit 2", dut.u_buf.o_occ);
                end
                if (valid && ready) begin
                    if (exp_rd == exp_wr) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", odata);
                    end else begin
                        check("beat", 64'(odata), 64'(exp_beats[exp_rd]));
                        exp_rd++;
                    end
                end
                prev_stall = valid & ~ready;
                prev_fire  = valid & ready;
                prev_data  = odata;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int zeros;
        bit ready_pat [4];
        ready_pat[0] = 1'b1;
        ready_pat[1] = 1'b0;
        ready_pat[2] = 1'b0;
        ready_pat[3] = 1'b1;

        rst     = 1'b1;
        en      = 1'b0;
        ready   = 1'b0;
        inj_vld = 1'b0;
        tick();
        tick();
        check("rst_rden",  64'(rden),  64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_data",  64'(odata), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_perr",  64'(perr),  64'd0);
        rst = 1'b0;
        tick();

        // Single word, beats LSB lane first on consecutive cycles.
        fifo_put(64'h1111_2222_3333_4444);
        exp_put(16'h4444);
        exp_put(16'h3333);
        exp_put(16'h2222);
        exp_put(16'h1111);
        en      = 1'b1;
        ready   = 1'b1;
        gap_chk = 1'b1;
        c = 0;
        while (!valid && c < 20) begin
            tick();
            c++;
        end
        check("single_valid_seen", 64'(valid), 64'd1);
        en = 1'b0;
        wait_drain(50);
        gap_chk = 1'b0;
        repeat (3) tick();
        check("single_idle_valid", 64'(valid), 64'd0);
        check("single_idle_busy",  64'(busy),  64'd0);

        // Empty FIFO: response cycle plus four backoff cycles with no read.
        do_reset();
        en = 1'b1;
        c = 0;
        while (!rden && c < 20) begin
            tick();
            c++;
        end
        check("empty_first_rden", 64'(rden), 64'd1);
        tick();
        zeros = 0;
        while (!rden && zeros < 20) begin
            zeros++;
            tick();
        end
        check("empty_rden_gap", 64'(zeros), 64'd5);
        check("empty_perr", 64'(perr), 64'd0);
        en = 1'b0;
        repeat (8) tick();

        // Backpressure with three queued words.
        do_reset();
        fifo_put(64'h0123_4567_89AB_CDEF);
        fifo_put(64'hFEDC_BA98_7654_3210);
        fifo_put(64'h0F0F_1E1E_2D2D_3C3C);
        exp_put(16'hCDEF); exp_put(16'h89AB); exp_put(16'h4567); exp_put(16'h0123);
        exp_put(16'h3210); exp_put(16'h7654); exp_put(16'hBA98); exp_put(16'hFEDC);
        exp_put(16'h3C3C); exp_put(16'h2D2D); exp_put(16'h1E1E); exp_put(16'h0F0F);
        en = 1'b1;
        c = 0;
        while (exp_rd != exp_wr && c < 200) begin
            ready = ready_pat[c % 4];
            tick();
            c++;
        end
        check("bp_drain_done", 64'(exp_wr - exp_rd), 64'd0);
        ready = 1'b1;
        en    = 1'b0;
        repeat (8) tick();
        check("bp_perr", 64'(perr), 64'd0);

        // Streaming 40 random words at full rate.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [63:0] w;
            w = {$urandom(), $urandom()};
            fifo_put(w);
            for (int j = 0; j < 4; j++) begin
                exp_put(w[j*16 +: 16]);
            end
        end
        en      = 1'b1;
        ready   = 1'b1;
        gap_chk = 1'b1;
        wait_drain(600);
        gap_chk = 1'b0;
        en      = 1'b0;
        repeat (8) tick();
        check("stream_perr", 64'(perr), 64'd0);
        check("stream_busy", 64'(busy), 64'd0);

        // Protocol error: data valid with nothing in flight.
        do_reset();
        check("perr_before", 64'(perr), 64'd0);
        inj_vld = 1'b1;
        tick();
        inj_vld = 1'b0;
        check("perr_set",       64'(perr),  64'd1);
        check("perr_no_push",   64'(valid), 64'd0);
        repeat (5) tick();
        check("perr_sticky",    64'(perr),  64'd1);
        do_reset();
        check("perr_cleared",   64'(perr),  64'd0);

        // Reset while lane 2 of a buffered word is presented.
        fifo_put(64'h5555_6666_7777_8888);
        exp_put(16'h8888);
        exp_put(16'h7777);
        exp_put(16'h6666);
        exp_put(16'h5555);
        en    = 1'b1;
        ready = 1'b1;
        c = 0;
        while ((exp_wr - exp_rd) != 2 && c < 30) begin
            tick();
            if (valid) en = 1'b0;
            c++;
        end
        en = 1'b0;
        check("midrst_lane2_reached", 64'(exp_wr - exp_rd), 64'd2);
        check("midrst_data_lane2", 64'(odata), 64'h6666);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_data",  64'(odata), 64'd0);
        check("midrst_busy",  64'(busy),  64'd0);
        check("midrst_rden",  64'(rden),  64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        fifo_put(64'hAAAA_BBBB_CCCC_DDDD);
        exp_put(16'hDDDD);
        exp_put(16'hCCCC);
        exp_put(16'hBBBB);
        exp_put(16'hAAAA);
        en = 1'b1;
        c = 0;
        while (!valid && c < 20) begin
            tick();
            c++;
        end
        check("midrst_first_beat", 64'(odata), 64'hDDDD);
        en = 1'b0;
        wait_drain(50);
        repeat (6) tick();
        check("midrst_perr", 64'(perr), 64'd0);
        check("midrst_idle_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
